pal_pad_sequencer: RTL and testbench
====================================

// Module: pal_pad_sequencer
// PURPOSE
//  Initiator side of the PAL clock-inhibit scheme. Watches the VDG sync outputs,
//  decides when the VDG must be frozen for PAL padding lines, and drives Line24
//  (pad window) plus VClkPulse (one strobe per padded line) into the clock
//  interposer. While the VDG is frozen it synthesises the missing horizontal
//  sync so the PAL encoder still sees a continuous line structure.
// PARAMETERS
//  PAD_LINES  25   synthesised lines inserted per field (odd-field; 2x25 = 50 extra)
//  LINE_CLKS  228  VClkEn strobes per synthesised line (one full VDG line period)
//  HS_CLKS    16   VClkEn strobes PadHS held low at start of each synthesised line
//  MAX_LINES  300  ACTIVE-state HS count with no FS before watchdog fires
// PORTS
//  Clk        in   1  system clock (all logic on rising edge)
//  Reset      in   1  asynchronous, active-high reset
//  VClkEn     in   1  one-Clk strobe per VDG pixel clock (free-running, never inhibited)
//  nHS        in   1  VDG horizontal sync, async, active-low
//  nFS        in   1  VDG field sync, async, active-low
//  Line24     out  1  pad window; high = interposer must inhibit VDG clock
//  VClkPulse  out  1  one-Clk strobe at end of each synthesised line
//  PadHS      out  1  synthesised hsync, active-low, valid only while Line24=1
//  LineCount  out  9  HS count in ACTIVE / pad-line index in PAD
//  FieldErr   out  1  sticky: watchdog fired; cleared only by Reset
// BEHAVIOUR
//  Reset: Line24=0, VClkPulse=0, PadHS=1, LineCount=0, FieldErr=0, state=IDLE.
//  Sync: nHS/nFS through 2-flop synchronisers; edge detect on synchronised value;
//   edge seen 3 Clk after pin change. Edges act only in states listed below.
//  States: IDLE -> ACTIVE -> PAD -> ACTIVE ...
//   IDLE: ignore nHS; nFS falling edge -> ACTIVE, LineCount=0.
//   ACTIVE: nHS falling edge -> LineCount+1. nFS falling edge -> PAD, LineCount=0,
//    Line24=1 on the same Clk as the state change (registered, 1 Clk after edge).
//    LineCount reaching MAX_LINES -> FieldErr=1, state=IDLE, LineCount=0.
//   PAD: dot counter advances on VClkEn only; counts 0..LINE_CLKS-1 and wraps.
//    PadHS=0 while dot counter < HS_CLKS, else 1. At wrap (dot=LINE_CLKS-1 and
//    VClkEn): VClkPulse=1 for exactly 1 Clk, LineCount+1. When LineCount reaches
//    PAD_LINES at a wrap -> ACTIVE, Line24=0, LineCount=0, PadHS=1, same Clk.
//    nHS/nFS edges in PAD are ignored (VDG is frozen; glitches must not re-arm).
//  Counter widths: LineCount 9 bits, saturating never needed (MAX_LINES<512);
//   dot counter 8 bits; LINE_CLKS must be <=256, HS_CLKS < LINE_CLKS.
//  Simultaneous nHS and nFS edges in ACTIVE: FS wins; LineCount cleared, not +1.
//  VClkEn absent: PAD state holds indefinitely, outputs static, no pulses.
//  Reset mid-PAD: immediate async return to reset values; VDG released at once.
//  Exactly PAD_LINES VClkPulse strobes per PAD visit; none outside PAD.
// TESTING
//  1 Reset, VClkEn every Clk, nFS fall -> IDLE->ACTIVE, Line24=0, LineCount=0.
//  2 ACTIVE, 10 nHS pulses then nFS fall -> LineCount=10 before FS; Line24=1
//    4 Clk after nFS pin falls; LineCount=0.
//  3 PAD with VClkEn every Clk -> 25 VClkPulse strobes, 228 Clk apart; PadHS low
//    16 Clk each line; Line24 falls on Clk of 25th strobe.
//  4 ACTIVE, 300 nHS with no nFS -> FieldErr=1, state IDLE; further nHS ignored
//    until next nFS; FieldErr stays 1.
//  5 Assert Reset at pad line 12 -> Line24=0, PadHS=1, LineCount=0 asynchronously.
//  6 VClkEn every 4th Clk in PAD -> strobes 912 Clk apart; nFS toggles in PAD ignored.

Source files
------------

// File: rtl/pal_pad_sequencer.sv
// pal_pad_sequencer: freezes the VDG for PAL padding lines and synthesises hsync while it is frozen
module pal_pad_sequencer #(
    parameter int PAD_LINES = 25,
    parameter int LINE_CLKS = 228,
    parameter int HS_CLKS   = 16,
    parameter int MAX_LINES = 300
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       vclk_en_i,
    input  logic       n_hs_i,
    input  logic       n_fs_i,
    output logic       line24_o,
    output logic       vclk_pulse_o,
    output logic       pad_hs_o,
    output logic [8:0] line_count_o,
    output logic       field_err_o
);
    typedef enum logic [1:0] {IDLE, ACTIVE, PAD} state_t;

    localparam logic [7:0] DOT_LAST = 8'(LINE_CLKS - 1);
    localparam logic [7:0] HS_END   = 8'(HS_CLKS);
    localparam logic [8:0] PAD_LAST = 9'(PAD_LINES - 1);
    localparam logic [8:0] MAX_LAST = 9'(MAX_LINES - 1);

    state_t     state_q;
    logic [2:0] hs_sync_q, fs_sync_q;
    logic       hs_fall_q, fs_fall_q;
    logic [7:0] dot_q;
    logic [8:0] line_count_q;
    logic       line24_q, vclk_pulse_q, pad_hs_q, field_err_q;

    assign line24_o     = line24_q;
    assign vclk_pulse_o = vclk_pulse_q;
    assign pad_hs_o     = pad_hs_q;
    assign line_count_o = line_count_q;
    assign field_err_o  = field_err_q;

    // two synchroniser flops, a history flop, then a registered falling-edge strobe
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hs_sync_q <= '1;
            fs_sync_q <= '1;
            hs_fall_q <= 1'b0;
            fs_fall_q <= 1'b0;
        end else begin
            hs_sync_q <= {hs_sync_q[1:0], n_hs_i};
            fs_sync_q <= {fs_sync_q[1:0], n_fs_i};
            hs_fall_q <= hs_sync_q[2] & ~hs_sync_q[1];
            fs_fall_q <= fs_sync_q[2] & ~fs_sync_q[1];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            dot_q        <= '0;
            line_count_q <= '0;
            line24_q     <= 1'b0;
            vclk_pulse_q <= 1'b0;
            pad_hs_q     <= 1'b1;
            field_err_q  <= 1'b0;
        end else begin
            vclk_pulse_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (fs_fall_q) begin
                        state_q      <= ACTIVE;
                        line_count_q <= '0;
                    end
                end
                ACTIVE: begin
                    if (fs_fall_q) begin
                        state_q      <= PAD;
                        line_count_q <= '0;
                        line24_q     <= 1'b1;
                        pad_hs_q     <= 1'b0;
                        dot_q        <= '0;
                    end else if (hs_fall_q) begin
                        if (line_count_q == MAX_LAST) begin
                            field_err_q  <= 1'b1;
                            state_q      <= IDLE;
                            line_count_q <= '0;
                        end else begin
                            line_count_q <= line_count_q + 9'd1;
                        end
                    end
                end
                PAD: begin
                    // sync edges are deliberately ignored here: the VDG is frozen
                    if (vclk_en_i) begin
                        if (dot_q == DOT_LAST) begin
                            dot_q        <= '0;
                            vclk_pulse_q <= 1'b1;
                            if (line_count_q == PAD_LAST) begin
                                state_q      <= ACTIVE;
                                line24_q     <= 1'b0;
                                line_count_q <= '0;
                                pad_hs_q     <= 1'b1;
                            end else begin
                                line_count_q <= line_count_q + 9'd1;
                                pad_hs_q     <= 1'b0;
                            end
                        end else begin
                            dot_q    <= dot_q + 8'd1;
                            pad_hs_q <= (dot_q + 8'd1) >= HS_END;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pal_pad_sequencer.sv
// tb_pal_pad_sequencer: randomized scoreboard bench for the PAL pad sequencer
module tb_pal_pad_sequencer;
    logic       clk = 1'b0, rst = 1'b1, vclk_en = 1'b0, n_hs = 1'b1, n_fs = 1'b1;
    logic       line24, vclk_pulse, pad_hs, field_err;
    logic [8:0] line_count;

    int tests = 0, fails = 0, cyc = 0, per = 1, pops = 0, low_cnt = 0;

    typedef struct {
        int cyc;
        int lc;
        int l24;
        int low;
    } exp_t;
    exp_t q[$];

    pal_pad_sequencer dut (
        .clk_i(clk), .rst_i(rst), .vclk_en_i(vclk_en), .n_hs_i(n_hs), .n_fs_i(n_fs),
        .line24_o(line24), .vclk_pulse_o(vclk_pulse), .pad_hs_o(pad_hs),
        .line_count_o(line_count), .field_err_o(field_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    // VClkEn is high at posedge m exactly when m is a multiple of per
    always @(negedge clk) vclk_en = ((cyc + 1) % per) == 0;

    task automatic chk(input string name, input int act, input int exp_v);
        tests++;
        if (act != exp_v) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
        end
    endtask

    // Pad visit model: each line lasts LINE_CLKS VClkEn strobes counted after entry,
    // hsync stays low until the 16th strobe of the line.
    task automatic push_pad(input int t);
        int m, start, ens, c16;
        exp_t e;
        m = t;
        start = t;
        for (int k = 1; k <= 25; k++) begin
            ens = 0;
            c16 = 0;
            while (ens < 228) begin
                m++;
                if (m % per == 0) begin
                    ens++;
                    if (ens == 16) c16 = m;
                end
            end
            e.cyc = m;
            e.lc  = (k == 25) ? 0 : k;
            e.l24 = (k == 25) ? 0 : 1;
            e.low = c16 - start;
            q.push_back(e);
            start = m;
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (rst) begin
            low_cnt = 0;
        end else begin
            if (vclk_pulse) begin
                if (q.size() == 0) begin
                    chk("unexpected_pulse", 1, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("pulse_cycle", cyc, e.cyc);
                    chk("pulse_line_count", int'(line_count), e.lc);
                    chk("pulse_line24", int'(line24), e.l24);
                    chk("padhs_low_clks", low_cnt, e.low);
                    pops++;
                end
                low_cnt = 0;
            end
            if (!pad_hs) low_cnt++;
        end
    end

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic hs_pulse();
        @(negedge clk);
        n_hs = 1'b0;
        settle(3);
        n_hs = 1'b1;
        settle(5);
    endtask

    task automatic enter_pad(input bit with_hs);
        int c;
        @(negedge clk);
        n_fs = 1'b0;
        if (with_hs) n_hs = 1'b0;
        c = cyc;
        push_pad(c + 4);
        repeat (3) @(posedge clk);
        #1 chk("line24_before_entry", int'(line24), 0);
        @(posedge clk);
        #1 chk("line24_entry", int'(line24), 1);
        chk("lc_entry", int'(line_count), 0);
        @(negedge clk);
        n_hs = 1'b1;
    endtask

    task automatic toggle_pins(input int n);
        repeat (n) begin
            @(negedge clk);
            n_fs = 1'($urandom_range(0, 1));
            n_hs = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        n_fs = 1'b1;
        n_hs = 1'b1;
    endtask

    task automatic wait_pops(input int target, input int limit);
        int n = 0;
        while (pops < target && n < limit) begin
            @(posedge clk);
            n++;
        end
        #2;
        if (pops < target) chk("pulse_timeout", pops, target);
    endtask

    task automatic check_exit();
        settle(5);
        chk("exit_line24", int'(line24), 0);
        chk("exit_lc", int'(line_count), 0);
        chk("exit_padhs", int'(pad_hs), 1);
        chk("queue_drained", q.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got cycle %0d, required finish", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int n, base;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_line24", int'(line24), 0);
        chk("reset_pulse", int'(vclk_pulse), 0);
        chk("reset_padhs", int'(pad_hs), 1);
        chk("reset_lc", int'(line_count), 0);
        chk("reset_err", int'(field_err), 0);
        @(negedge clk);
        rst = 1'b0;

        repeat (3) hs_pulse();
        chk("idle_ignores_hs", int'(line_count), 0);
        @(negedge clk);
        n_fs = 1'b0;
        settle(8);
        n_fs = 1'b1;
        chk("active_line24", int'(line24), 0);
        chk("active_lc", int'(line_count), 0);
        settle(8);

        repeat (10) hs_pulse();
        chk("hs_count_10", int'(line_count), 10);
        base = pops;
        enter_pad(1'b0);
        settle(10);
        n_fs = 1'b1;
        wait_pops(base + 25, 25 * 228 * per + 200);
        check_exit();

        for (int r = 0; r < 2; r++) begin
            per = (r == 0) ? 4 : int'($urandom_range(2, 3));
            n = $urandom_range(1, 40);
            repeat (n) hs_pulse();
            chk("hs_count_rand", int'(line_count), n);
            base = pops;
            enter_pad(1'b1);
            toggle_pins(200);
            wait_pops(base + 25, 25 * 228 * per + 200);
            check_exit();
        end

        per = 1;
        repeat (299) hs_pulse();
        chk("wd_lc_299", int'(line_count), 299);
        chk("wd_err_before", int'(field_err), 0);
        hs_pulse();
        chk("wd_err_fired", int'(field_err), 1);
        chk("wd_lc_cleared", int'(line_count), 0);
        repeat (3) hs_pulse();
        chk("wd_idle_ignores_hs", int'(line_count), 0);
        @(negedge clk);
        n_fs = 1'b0;
        settle(8);
        n_fs = 1'b1;
        repeat (3) hs_pulse();
        chk("wd_rearm_lc", int'(line_count), 3);
        chk("wd_err_sticky", int'(field_err), 1);

        per = $urandom_range(1, 2);
        base = pops;
        enter_pad(1'b0);
        settle(4);
        n_fs = 1'b1;
        wait_pops(base + 12, 12 * 228 * per + 200);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("midpad_line24", int'(line24), 0);
        chk("midpad_padhs", int'(pad_hs), 1);
        chk("midpad_lc", int'(line_count), 0);
        chk("midpad_err", int'(field_err), 0);
        chk("midpad_pulse", int'(vclk_pulse), 0);
        q.delete();
        settle(2);
        rst = 1'b0;
        settle(300);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
